// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    // Number of in-flight stages tracked: slot0=EXE, slot1=MEM, slot2=WB.
    localparam int SB_DEPTH = 3;

    // Stall counter saturation value.
    localparam logic [15:0] SB_STALL_MAX = 16'hFFFF;

    // One in-flight instruction as seen by the scoreboard.
    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_r;
        logic       s;
        logic [3:0] dest;
    } slot_t;

    // One-hot decode of a register index.
    function automatic logic [15:0] reg_onehot(input logic [3:0] r);
        return 16'h0001 << r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_slot_match.sv
// Per-slot comparator: tells the top whether this slot produces either
// decode source, whether it is a load, whether it will update the flags,
// and which register it is going to write.
module sb_slot_match
    import hazard_scoreboard_pkg::*;
(
    input  slot_t       slot,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    output logic        m1,
    output logic        m2,
    output logic        load,
    output logic        flag,
    output logic [15:0] dest_onehot
);

    logic writes;

    // A slot only counts as a producer if it is real and writes a register.
    always_comb begin
        writes      = slot.valid & slot.wb_en;
        m1          = writes & (slot.dest == src1);
        m2          = writes & (slot.dest == src2);
        load        = slot.valid & slot.mem_r;
        flag        = slot.valid & slot.s;
        dest_onehot = writes ? reg_onehot(slot.dest) : 16'h0000;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side scoreboard: tracks in-flight register/flag writers in
// EXE/MEM/WB, raises the decode stall and counts stall cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter bit FWD_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [3:0]  id_src1,
    input  logic        id_src1_used,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    input  logic        id_wb_en,
    input  logic        id_mem_r,
    input  logic [3:0]  id_dest,
    input  logic        id_s,
    input  logic        id_uses_sr,
    output logic        hazard,
    output logic        issue,
    output logic [15:0] pending,
    output logic        sr_pending,
    output logic [15:0] stall_count
);

    slot_t              slots [DEPTH];
    logic [DEPTH-1:0]   m1;
    logic [DEPTH-1:0]   m2;
    logic [DEPTH-1:0]   load;
    logic [DEPTH-1:0]   flag;
    logic [DEPTH-1:0]   blocks;
    logic [15:0]        onehot [DEPTH];
    logic               raw;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_match
            sb_slot_match u_match (
                .slot        (slots[k]),
                .src1        (id_src1),
                .src2        (id_src2),
                .m1          (m1[k]),
                .m2          (m2[k]),
                .load        (load[k]),
                .flag        (flag[k]),
                .dest_onehot (onehot[k])
            );
        end
    endgenerate

    // With forwarding only a load sitting in EXE can still block a consumer;
    // without it every in-flight producer blocks until it retires.
    always_comb begin
        blocks = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (FWD_EN) begin
                blocks[i] = (i == 0) & load[i];
            end else begin
                blocks[i] = 1'b1;
            end
        end
    end

    // Same-cycle hazard and issue decisions from decode inputs and slots.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending | onehot[i];
        end
        sr_pending = |flag;
        raw        = (id_src1_used & |(m1 & blocks)) | (id_two_src & |(m2 & blocks));
        hazard     = rst & id_valid & (raw | (id_uses_sr & sr_pending));
        issue      = rst & id_valid & ~hazard & ~flush & ~freeze;
    end

    // In-flight shift register: advance one stage per unfrozen cycle,
    // loading the issuing instruction or a bubble into EXE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (!freeze) begin
            for (int i = 1; i < DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
            if (issue) begin
                slots[0] <= '{valid: 1'b1, wb_en: id_wb_en, mem_r: id_mem_r,
                              s: id_s, dest: id_dest};
            end else begin
                slots[0] <= '0;
            end
        end
    end

    // Saturating count of cycles in which decode was actually held back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (!freeze && hazard && (stall_count != SB_STALL_MAX)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: one instance without and one
// with forwarding, driven in lockstep and compared to an in-flight model.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        id_valid;
    logic [3:0]  id_src1;
    logic        id_src1_used;
    logic [3:0]  id_src2;
    logic        id_two_src;
    logic        id_wb_en;
    logic        id_mem_r;
    logic [3:0]  id_dest;
    logic        id_s;
    logic        id_uses_sr;

    logic [1:0]  hz;
    logic [1:0]  iss;
    logic [1:0]  srp;
    logic [15:0] pend [2];
    logic [15:0] cnt  [2];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: every issued instruction with its age in unfrozen cycles.
    typedef struct {
        int cfg;
        int age;
        bit wb_en;
        bit mem_r;
        bit s;
        int dest;
    } mrec_t;

    mrec_t inflight [$];
    int    exp_count [2];
    bit    seen_hz  [2];
    bit    seen_iss [2];
    int    seen_cnt [2];

    hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
        .id_mem_r(id_mem_r), .id_dest(id_dest), .id_s(id_s), .id_uses_sr(id_uses_sr),
        .hazard(hz[0]), .issue(iss[0]), .pending(pend[0]),
        .sr_pending(srp[0]), .stall_count(cnt[0])
    );

    hazard_scoreboard #(.DEPTH(DEPTH), .FWD_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
        .id_mem_r(id_mem_r), .id_dest(id_dest), .id_s(id_s), .id_uses_sr(id_uses_sr),
        .hazard(hz[1]), .issue(iss[1]), .pending(pend[1]),
        .sr_pending(srp[1]), .stall_count(cnt[1])
    );

    // Free-running clock.
    initial forever #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_compared++;
        if (obs !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit writes_reg(input mrec_t r, input logic [3:0] idx);
        return r.wb_en && (r.dest == int'(idx));
    endfunction

    function automatic bit model_hazard(input int cfg);
        bit raw = 0;
        bit flags = 0;
        bit visible;
        if (!rst || !id_valid) return 1'b0;
        foreach (inflight[i]) begin
            if (inflight[i].cfg == cfg) begin
                visible = (cfg == 0) || (inflight[i].age == 0 && inflight[i].mem_r);
                if (visible && ((id_src1_used && writes_reg(inflight[i], id_src1)) ||
                                (id_two_src && writes_reg(inflight[i], id_src2))))
                    raw = 1;
                if (inflight[i].s) flags = 1;
            end
        end
        return raw || (id_uses_sr && flags);
    endfunction

    function automatic bit model_issue(input int cfg);
        return rst && id_valid && !model_hazard(cfg) && !flush && !freeze;
    endfunction

    function automatic logic [15:0] model_pending(input int cfg);
        logic [15:0] p = '0;
        foreach (inflight[i])
            if (inflight[i].cfg == cfg && inflight[i].wb_en) p[inflight[i].dest] = 1'b1;
        return p;
    endfunction

    function automatic bit model_sr_pending(input int cfg);
        foreach (inflight[i])
            if (inflight[i].cfg == cfg && inflight[i].s) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs of this cycle.
    task automatic advance_model();
        bit    do_issue [2];
        mrec_t r;
        if (!rst || freeze) return;
        for (int c = 0; c < 2; c++) begin
            do_issue[c] = model_issue(c);
            if (model_hazard(c) && exp_count[c] < 65535) exp_count[c]++;
        end
        for (int i = inflight.size() - 1; i >= 0; i--) begin
            r = inflight[i];
            r.age++;
            if (r.age >= DEPTH) inflight.delete(i);
            else inflight[i] = r;
        end
        for (int c = 0; c < 2; c++) begin
            if (do_issue[c]) begin
                r = '{cfg: c, age: 0, wb_en: id_wb_en, mem_r: id_mem_r, s: id_s, dest: int'(id_dest)};
                inflight.push_back(r);
            end
        end
    endtask

    // Check both instances mid-cycle, then step the model across the edge.
    task automatic run_cycle();
        @(negedge clk);
        if (!rst) begin
            inflight.delete();
            exp_count[0] = 0;
            exp_count[1] = 0;
        end
        for (int c = 0; c < 2; c++) begin
            check_output($sformatf("hazard_cfg%0d", c), {31'b0, hz[c]}, {31'b0, model_hazard(c)});
            check_output($sformatf("issue_cfg%0d", c), {31'b0, iss[c]}, {31'b0, model_issue(c)});
            check_output($sformatf("pending_cfg%0d", c), {16'b0, pend[c]}, {16'b0, model_pending(c)});
            check_output($sformatf("sr_pending_cfg%0d", c), {31'b0, srp[c]}, {31'b0, model_sr_pending(c)});
            check_output($sformatf("stall_count_cfg%0d", c), {16'b0, cnt[c]}, 32'(exp_count[c]));
            seen_hz[c]  = hz[c];
            seen_iss[c] = iss[c];
            seen_cnt[c] = int'(cnt[c]);
        end
        advance_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input bit v, input logic [3:0] s1, input bit u1,
                             input logic [3:0] s2, input bit two, input bit wb,
                             input bit mr, input logic [3:0] d, input bit s, input bit usr);
        id_valid     = v;
        id_src1      = s1;
        id_src1_used = u1;
        id_src2      = s2;
        id_two_src   = two;
        id_wb_en     = wb;
        id_mem_r     = mr;
        id_dest      = d;
        id_s         = s;
        id_uses_sr   = usr;
    endtask

    task automatic idle_cycles(input int n);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // Hold the current decode instruction until instance cfg issues it,
    // returning how many hazard cycles it saw (bounded).
    task automatic hold_until_issue(input int cfg, output int stalls, output bit issued);
        stalls = 0;
        issued = 0;
        for (int i = 0; i < 8 && !issued; i++) begin
            run_cycle();
            if (seen_hz[cfg]) stalls++;
            if (seen_iss[cfg]) issued = 1;
        end
    endtask

    task automatic apply_stimulus();
        int stalls;
        bit issued;

        // Reset, then idle decode.
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        run_cycle();
        rst = 1'b1;
        idle_cycles(5);
        check_output("idle_pending", {16'b0, pend[0]}, 32'h0);

        // RAW without forwarding: ADD R1 then SUB R2,R1,R3.
        set_instr(1, 4'd2, 1, 4'd3, 1, 1, 0, 4'd1, 0, 0);
        run_cycle();
        set_instr(1, 4'd1, 1, 4'd3, 1, 1, 0, 4'd2, 0, 0);
        hold_until_issue(0, stalls, issued);
        check_output("raw_stalls", 32'(stalls), 32'd3);
        check_output("raw_issued", {31'b0, issued}, 32'd1);
        check_output("raw_stall_count", 32'(seen_cnt[0]), 32'd3);
        idle_cycles(3);

        // Load-use with forwarding: LDR R4 then ADD R5,R4,R4.
        set_instr(1, 4'd0, 0, 4'd0, 0, 1, 1, 4'd4, 0, 0);
        run_cycle();
        set_instr(1, 4'd4, 1, 4'd4, 1, 1, 0, 4'd5, 0, 0);
        hold_until_issue(1, stalls, issued);
        check_output("load_use_bubbles", 32'(stalls), 32'd1);
        idle_cycles(3);

        // Non-load producer with forwarding: MOV R6 then ADD R7,R6,R6.
        set_instr(1, 4'd0, 0, 4'd0, 0, 1, 0, 4'd6, 0, 0);
        run_cycle();
        set_instr(1, 4'd6, 1, 4'd6, 1, 1, 0, 4'd7, 0, 0);
        hold_until_issue(1, stalls, issued);
        check_output("alu_use_bubbles", 32'(stalls), 32'd0);
        idle_cycles(3);

        // Flags: ADDS R8 then MOVEQ R9.
        set_instr(1, 4'd0, 0, 4'd0, 0, 1, 0, 4'd8, 1, 0);
        run_cycle();
        set_instr(1, 4'd0, 0, 4'd0, 0, 1, 0, 4'd9, 0, 1);
        hold_until_issue(1, stalls, issued);
        check_output("flag_stalls", 32'(stalls), 32'd3);
        idle_cycles(3);

        // Flags: ADDS R8 then MOVAL R9 does not wait.
        set_instr(1, 4'd0, 0, 4'd0, 0, 1, 0, 4'd8, 1, 0);
        run_cycle();
        set_instr(1, 4'd0, 0, 4'd0, 0, 1, 0, 4'd9, 0, 0);
        hold_until_issue(0, stalls, issued);
        check_output("moval_stalls", 32'(stalls), 32'd0);
        idle_cycles(3);

        // Freeze in the middle of a RAW stall.
        set_instr(1, 4'd0, 0, 4'd0, 0, 1, 0, 4'd1, 0, 0);
        run_cycle();
        set_instr(1, 4'd1, 1, 4'd0, 0, 1, 0, 4'd2, 0, 0);
        run_cycle();
        freeze = 1'b1;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            if (seen_hz[0]) stalls++;
        end
        check_output("freeze_hazard_held", 32'(stalls), 32'd4);
        freeze = 1'b0;
        hold_until_issue(0, stalls, issued);
        check_output("freeze_remaining_stalls", 32'(stalls), 32'd2);
        idle_cycles(3);

        // Flush kills an independent decode instruction.
        flush = 1'b1;
        set_instr(1, 4'd3, 1, 4'd4, 1, 1, 0, 4'd5, 1, 0);
        run_cycle();
        check_output("flush_issue", {31'b0, seen_iss[0]}, 32'd0);
        flush = 1'b0;
        idle_cycles(1);

        // Asynchronous reset in the middle of a stall.
        set_instr(1, 4'd0, 0, 4'd0, 0, 1, 0, 4'd1, 0, 0);
        run_cycle();
        set_instr(1, 4'd1, 1, 4'd0, 0, 1, 0, 4'd2, 0, 0);
        run_cycle();
        rst = 1'b0;
        run_cycle();
        check_output("reset_hazard", {31'b0, seen_hz[0]}, 32'd0);
        check_output("reset_stall_count", 32'(seen_cnt[0]), 32'd0);
        rst = 1'b1;
        idle_cycles(2);

        // Randomized traffic over a small register range to provoke hits.
        for (int n = 0; n < 800; n++) begin
            rst    = ($urandom_range(63) != 0);
            freeze = ($urandom_range(9) == 0);
            flush  = ($urandom_range(9) == 0);
            set_instr($urandom_range(4) != 0,
                      4'($urandom_range(3)), $urandom_range(1),
                      4'($urandom_range(3)), $urandom_range(1),
                      $urandom_range(9) < 7, $urandom_range(9) < 3,
                      4'($urandom_range(3)), $urandom_range(9) < 3,
                      $urandom_range(9) < 3);
            run_cycle();
        end
    endtask

    initial begin
        apply_stimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
